// File: rtl/bus_copy_master_pkg.sv
// Shared constants for the copy master: address windows, FSM states, default watchdog limit,
// and the window range check used by the job check step.
package bus_copy_master_pkg;

    localparam int ADDR_W = 16;

    localparam logic [ADDR_W-1:0] S0_LO = 16'h0000;
    localparam logic [ADDR_W-1:0] S0_HI = 16'h07FF;
    localparam logic [ADDR_W-1:0] S1_LO = 16'h7000;
    localparam logic [ADDR_W-1:0] S1_HI = 16'h71FF;

    localparam int DEFAULT_TIMEOUT = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_RD_REQ,
        ST_RD_HOLD,
        ST_WR_REQ,
        ST_WR_HOLD,
        ST_FIN
    } state_e;

    function automatic logic in_window(input logic [ADDR_W:0]   first,
                                       input logic [ADDR_W:0]   last,
                                       input logic [ADDR_W-1:0] lo,
                                       input logic [ADDR_W-1:0] hi);
        return (first >= {1'b0, lo}) && (last <= {1'b0, hi});
    endfunction

    // The extra top bit of 'last' catches address wrap: a wrapped range can never sit under hi.
    function automatic logic range_ok(input logic [ADDR_W-1:0] base,
                                      input logic [ADDR_W:0]   count);
        logic [ADDR_W:0] first;
        logic [ADDR_W:0] last;
        first = {1'b0, base};
        last  = first + count - (ADDR_W+1)'(1);
        return in_window(first, last, S0_LO, S0_HI) || in_window(first, last, S1_LO, S1_HI);
    endfunction

endpackage

// File: rtl/bus_copy_master_if.sv
// Master-side bus connection between the copy master and the bus arbiter/decoder.
interface bus_copy_master_if
    import bus_copy_master_pkg::*;
#(
    parameter int AW = ADDR_W,
    parameter int DW = 64
) ();

    logic          m_req;
    logic          m_wr;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_dout;
    logic          m_grant;
    logic [DW-1:0] m_din;

    modport master (
        output m_req, m_wr, m_addr, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_dout,
        output m_grant, m_din
    );

endinterface

// File: rtl/bus_copy_master_beat_timer.sv
// Watchdog for one bus phase: counts cycles while enabled, restarts on clear,
// and flags expiry on the TIMEOUT-th cycle spent in the same phase.
module bus_copy_master_beat_timer
    import bus_copy_master_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = enable && (count_q >= CW'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bus_copy_master.sv
// Copy-job bus master: reads LEN words from SRC and writes each to DST, one bus beat per word.
// Optional COPY_CHECKSUM_EN adds a csum output holding the XOR of all words read in the job.
module bus_copy_master
    import bus_copy_master_pkg::*;
#(
    parameter int AW      = ADDR_W,
    parameter int DW      = 64,
    parameter int LENW    = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [AW-1:0]   src_addr,
    input  logic [AW-1:0]   dst_addr,
    input  logic [LENW-1:0] len,
    output logic            busy,
    output logic            done,
    output logic            err,
    bus_copy_master_if.master bus
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0]   csum
`endif
);

    state_e          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [LENW-1:0] rem_q, rem_d;
    logic [DW-1:0]   buf_q, buf_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            m_req_q, m_req_d;
    logic            m_wr_q, m_wr_d;
    logic [AW-1:0]   m_addr_q, m_addr_d;
    logic [DW-1:0]   m_dout_q, m_dout_d;
    logic            job_err;
    logic            timer_expired;
    logic            src_ok;
    logic            dst_ok;
`ifdef COPY_CHECKSUM_EN
    logic [DW-1:0]   csum_q, csum_d;
`endif

    assign src_ok = range_ok(src_q, (ADDR_W+1)'(rem_q));
    assign dst_ok = range_ok(dst_q, (ADDR_W+1)'(rem_q));

    bus_copy_master_beat_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (state_d != state_q),
        .enable  (state_q inside {ST_RD_REQ, ST_RD_HOLD, ST_WR_REQ, ST_WR_HOLD}),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            rem_q    <= '0;
            buf_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            m_req_q  <= 1'b0;
            m_wr_q   <= 1'b0;
            m_addr_q <= '0;
            m_dout_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            rem_q    <= rem_d;
            buf_q    <= buf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            m_req_q  <= m_req_d;
            m_wr_q   <= m_wr_d;
            m_addr_q <= m_addr_d;
            m_dout_q <= m_dout_d;
        end
    end

    // A beat only ends on grant low; a grant arriving in the expiry cycle still wins.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        buf_d   = buf_q;
        job_err = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = len;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rem_q == '0) begin
                    state_d = ST_FIN;
                end else if (src_ok && dst_ok) begin
                    state_d = ST_RD_REQ;
                end else begin
                    job_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_REQ: begin
                if (bus.m_grant) begin
                    state_d = ST_RD_HOLD;
                end else if (timer_expired) begin
                    job_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_RD_HOLD: begin
                if (!bus.m_grant) begin
                    state_d = ST_WR_REQ;
                end else begin
                    buf_d = bus.m_din;
                    if (timer_expired) begin
                        job_err = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WR_REQ: begin
                if (bus.m_grant) begin
                    state_d = ST_WR_HOLD;
                end else if (timer_expired) begin
                    job_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR_HOLD: begin
                if (!bus.m_grant) begin
                    src_d   = src_q + AW'(1);
                    dst_d   = dst_q + AW'(1);
                    rem_d   = rem_q - LENW'(1);
                    state_d = (rem_q == LENW'(1)) ? ST_FIN : ST_RD_REQ;
                end else if (timer_expired) begin
                    job_err = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Bus outputs follow the next state so they are already valid when the state is entered.
    always_comb begin
        busy_d   = (state_d != ST_IDLE);
        done_d   = (state_q == ST_FIN);
        err_d    = job_err;
        m_req_d  = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
        m_wr_d   = (state_d == ST_WR_REQ) || (state_d == ST_WR_HOLD);
        m_addr_d = m_addr_q;
        m_dout_d = m_dout_q;
        unique case (state_d)
            ST_RD_REQ, ST_RD_HOLD: begin
                m_addr_d = src_d;
            end
            ST_WR_REQ, ST_WR_HOLD: begin
                m_addr_d = dst_d;
                m_dout_d = buf_d;
            end
            default: begin
                m_addr_d = m_addr_q;
            end
        endcase
    end

`ifdef COPY_CHECKSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (state_q == ST_IDLE && start) begin
            csum_d = '0;
        end else if (state_q == ST_RD_HOLD && !bus.m_grant) begin
            csum_d = csum_q ^ buf_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign bus.m_req  = m_req_q;
    assign bus.m_wr   = m_wr_q;
    assign bus.m_addr = m_addr_q;
    assign bus.m_dout = m_dout_q;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: a bus responder backed by s0/s1 memory models checks every beat
// against a scoreboard of expected beats queued when each job is launched.
module tb_bus_copy_master;

    localparam int TIMEOUT_T = 32;

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [63:0] data;
    } beat_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic        busy;
    logic        done;
    logic        err;
`ifdef COPY_CHECKSUM_EN
    logic [63:0] csum;
`endif

    int checks;
    int failures;

    logic [63:0] s0 [0:2047];
    logic [63:0] s1 [0:511];
    beat_t       sb [$];

    bit          stall;
    int          beat_no;
    int          wr_beats;
    bit          active;
    int          hold_left;
    logic [63:0] cur_word;

    bus_copy_master_if #(.AW(16), .DW(64)) bus_if ();

    bus_copy_master #(
        .AW      (16),
        .DW      (64),
        .LENW    (8),
        .TIMEOUT (TIMEOUT_T)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .bus      (bus_if)
`ifdef COPY_CHECKSUM_EN
        ,
        .csum     (csum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] mem_read(input logic [15:0] a);
        if (a <= 16'h07FF) return s0[a[10:0]];
        if (a >= 16'h7000 && a <= 16'h71FF) return s1[a[8:0]];
        return 64'h0;
    endfunction

    task automatic mem_write(input logic [15:0] a, input logic [63:0] d);
        if (a <= 16'h07FF) s0[a[10:0]] = d;
        else if (a >= 16'h7000 && a <= 16'h71FF) s1[a[8:0]] = d;
    endtask

    // Expected beats for a clean copy: read src+i then write dst+i with the source word.
    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.wr   = 1'b0;
            b.addr = s + 16'(i);
            b.data = 64'h0;
            sb.push_back(b);
            b.wr   = 1'b1;
            b.addr = d + 16'(i);
            b.data = mem_read(s + 16'(i));
            sb.push_back(b);
        end
    endtask

    // Bus responder: grants at the negedge after m_req, holds grant 1 or 2 extra cycles,
    // and presents the real read word only on the last held cycle.
    initial begin
        beat_t exp_b;
        bus_if.m_grant = 1'b0;
        bus_if.m_din   = 64'h0;
        active    = 1'b0;
        hold_left = 0;
        beat_no   = 0;
        wr_beats  = 0;
        cur_word  = 64'h0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                bus_if.m_grant = 1'b0;
                active = 1'b0;
            end else if (!active) begin
                if (bus_if.m_req && !stall) begin
                    active         = 1'b1;
                    bus_if.m_grant = 1'b1;
                    bus_if.m_din   = 64'hDEAD_BEEF_0BAD_F00D;
                    hold_left      = 1 + (beat_no % 2);
                    beat_no++;
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("[TB] FAIL unexpected_beat: got wr=%0b addr=%h, required no beat",
                                 bus_if.m_wr, bus_if.m_addr);
                    end else begin
                        exp_b = sb.pop_front();
                        if (bus_if.m_wr !== exp_b.wr || bus_if.m_addr !== exp_b.addr) begin
                            failures++;
                            $display("[TB] FAIL beat_kind: got wr=%0b addr=%h, required wr=%0b addr=%h",
                                     bus_if.m_wr, bus_if.m_addr, exp_b.wr, exp_b.addr);
                        end
                        if (exp_b.wr) begin
                            checks++;
                            if (bus_if.m_dout !== exp_b.data) begin
                                failures++;
                                $display("[TB] FAIL wr_data: got %h, required %h",
                                         bus_if.m_dout, exp_b.data);
                            end
                        end
                    end
                    if (bus_if.m_wr) begin
                        mem_write(bus_if.m_addr, bus_if.m_dout);
                        wr_beats++;
                    end else begin
                        cur_word = mem_read(bus_if.m_addr);
                    end
                end
            end else if (hold_left > 0) begin
                bus_if.m_din = (hold_left == 1) ? cur_word : ~cur_word;
                hold_left--;
            end else begin
                bus_if.m_grant = 1'b0;
                active = 1'b0;
            end
        end
    end

    // Launches one job and samples status every negedge until done/err (or the bound runs out).
    task automatic run_job(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l,
                           input int extra_at,
                           output int n_done, output int n_err, output int n_busy,
                           output int n_req, output bit timed_out);
        n_done = 0; n_err = 0; n_busy = 0; n_req = 0; timed_out = 1'b1;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (busy) n_busy++;
            if (bus_if.m_req) n_req++;
            if (done) n_done++;
            if (err) n_err++;
            if (done || err) begin
                timed_out = 1'b0;
                break;
            end
            if (cyc == extra_at) begin
                start = 1'b1; src_addr = 16'h0100; dst_addr = 16'h7100; len = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        @(negedge clk);
        if (done) n_done++;
        if (err) n_err++;
        if (busy) n_busy++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, err, bus_if.m_req, bus_if.m_wr} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b, required 00000",
                     {busy, done, err, bus_if.m_req, bus_if.m_wr});
        end
        checks++;
        if (bus_if.m_addr !== 16'h0 || bus_if.m_dout !== 64'h0) begin
            failures++;
            $display("[TB] FAIL reset_bus: got addr=%h dout=%h, required 0/0",
                     bus_if.m_addr, bus_if.m_dout);
        end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus_if.m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_after_reset: got busy=%b m_req=%b, required 0/0",
                     busy, bus_if.m_req);
        end
    endtask

    task automatic test_copy(input logic [15:0] s, input logic [15:0] d, input int n, input string tag);
        int nd, ne, nb, nr;
        bit to;
        logic [63:0] src_words [$];
        for (int i = 0; i < n; i++) src_words.push_back(mem_read(s + 16'(i)));
        push_copy(s, d, n);
        run_job(s, d, 8'(n), -1, nd, ne, nb, nr, to);
        checks++;
        if (to || nd !== 1 || ne !== 0) begin
            failures++;
            $display("[TB] FAIL %s_status: got timeout=%0b done=%0d err=%0d, required 0/1/0", tag, to, nd, ne);
        end
        checks++;
        if (sb.size() !== 0) begin
            failures++;
            $display("[TB] FAIL %s_beats_left: got %0d, required 0", tag, sb.size());
            sb.delete();
        end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (mem_read(d + 16'(i)) !== src_words[i]) begin
                failures++;
                $display("[TB] FAIL %s_word%0d: got %h, required %h", tag, i, mem_read(d + 16'(i)), src_words[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_busy_end: got %b, required 0", tag, busy);
        end
    endtask

    task automatic test_zero_len();
        int nd, ne, nb, nr;
        bit to;
        run_job(16'h0010, 16'h7000, 8'd0, -1, nd, ne, nb, nr, to);
        checks++;
        if (to || nd !== 1 || ne !== 0 || nr !== 0 || nb !== 2) begin
            failures++;
            $display("[TB] FAIL zero_len: got to=%0b done=%0d err=%0d req=%0d busy=%0d, required 0/1/0/0/2",
                     to, nd, ne, nr, nb);
        end
    endtask

    task automatic test_window_reject();
        logic [15:0] srcs [4] = '{16'h07FE, 16'h0000, 16'h6FFF, 16'hFFFE};
        logic [15:0] dsts [4] = '{16'h7000, 16'h71FE, 16'h7000, 16'h7000};
        logic [7:0]  lens [4] = '{8'd4, 8'd4, 8'd1, 8'd4};
        int nd, ne, nb, nr;
        bit to;
        for (int k = 0; k < 4; k++) begin
            run_job(srcs[k], dsts[k], lens[k], -1, nd, ne, nb, nr, to);
            checks++;
            if (to || nd !== 0 || ne !== 1 || nr !== 0 || busy !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reject%0d: got to=%0b done=%0d err=%0d req=%0d busy=%b, required 0/0/1/0/0",
                         k, to, nd, ne, nr, busy);
            end
        end
    endtask

    task automatic test_timeout();
        int nd, ne, nb, nr;
        bit to;
        stall = 1'b1;
        run_job(16'h0000, 16'h7000, 8'd1, -1, nd, ne, nb, nr, to);
        stall = 1'b0;
        checks++;
        if (to || nd !== 0 || ne !== 1) begin
            failures++;
            $display("[TB] FAIL timeout_status: got to=%0b done=%0d err=%0d, required 0/0/1", to, nd, ne);
        end
        checks++;
        if (nr !== TIMEOUT_T || nb !== TIMEOUT_T + 1) begin
            failures++;
            $display("[TB] FAIL timeout_len: got req=%0d busy=%0d, required %0d/%0d",
                     nr, nb, TIMEOUT_T, TIMEOUT_T + 1);
        end
        checks++;
        if (bus_if.m_req !== 1'b0) begin
            failures++;
            $display("[TB] FAIL timeout_req_end: got %b, required 0", bus_if.m_req);
        end
    endtask

    task automatic test_reset_mid_job();
        int base;
        bit seen;
        base = wr_beats;
        seen = 1'b0;
        push_copy(16'h0020, 16'h7010, 4);
        @(negedge clk);
        src_addr = 16'h0020; dst_addr = 16'h7010; len = 8'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(posedge clk);
            if (wr_beats == base + 2) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL midjob_reach_wr2: got %0d writes, required %0d", wr_beats - base, 2);
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, err, bus_if.m_req, bus_if.m_wr} !== 5'b0 ||
            bus_if.m_addr !== 16'h0 || bus_if.m_dout !== 64'h0) begin
            failures++;
            $display("[TB] FAIL midjob_reset: got flags=%b addr=%h dout=%h, required 0/0/0",
                     {busy, done, err, bus_if.m_req, bus_if.m_wr}, bus_if.m_addr, bus_if.m_dout);
        end
        sb.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_copy(16'h0030, 16'h7020, 3, "after_reset");
    endtask

    task automatic test_back_to_back();
        int nd, ne, nb, nr;
        bit to;
        s0[11'h040] = 64'h1; s0[11'h041] = 64'h2; s0[11'h042] = 64'h4;
        s0[11'h050] = 64'h8; s0[11'h051] = 64'h10;
        push_copy(16'h0040, 16'h7040, 3);
        run_job(16'h0040, 16'h7040, 8'd3, 3, nd, ne, nb, nr, to);
        checks++;
        if (to || nd !== 1 || ne !== 0 || sb.size() !== 0) begin
            failures++;
            $display("[TB] FAIL busy_start: got to=%0b done=%0d err=%0d left=%0d, required 0/1/0/0",
                     to, nd, ne, sb.size());
            sb.delete();
        end
        checks++;
        if (s1[9'h040] !== 64'h1 || s1[9'h041] !== 64'h2 || s1[9'h042] !== 64'h4) begin
            failures++;
            $display("[TB] FAIL busy_start_data: got %h %h %h, required 1 2 4",
                     s1[9'h040], s1[9'h041], s1[9'h042]);
        end
`ifdef COPY_CHECKSUM_EN
        checks++;
        if (csum !== 64'h7) begin
            failures++;
            $display("[TB] FAIL csum_first: got %h, required %h", csum, 64'h7);
        end
`endif
        push_copy(16'h0050, 16'h7050, 2);
        run_job(16'h0050, 16'h7050, 8'd2, -1, nd, ne, nb, nr, to);
        checks++;
        if (to || nd !== 1 || ne !== 0 || sb.size() !== 0) begin
            failures++;
            $display("[TB] FAIL second_job: got to=%0b done=%0d err=%0d left=%0d, required 0/1/0/0",
                     to, nd, ne, sb.size());
            sb.delete();
        end
`ifdef COPY_CHECKSUM_EN
        checks++;
        if (csum !== 64'h18) begin
            failures++;
            $display("[TB] FAIL csum_second: got %h, required %h", csum, 64'h18);
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        checks   = 0;
        failures = 0;
        stall    = 1'b0;
        reset_n  = 1'b0;
        start    = 1'b0;
        src_addr = 16'h0;
        dst_addr = 16'h0;
        len      = 8'h0;
        for (int i = 0; i < 2048; i++) s0[i] = {$urandom, $urandom};
        for (int i = 0; i < 512; i++) s1[i] = 64'h0;

        test_reset();
        test_copy(16'h0010, 16'h7000, 4, "copy");
        test_zero_len();
        test_window_reject();
        test_copy(16'h07FC, 16'h71FC, 4, "edge");
        test_timeout();
        test_reset_mid_job();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
